// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with a word-organised backing array.
// Optional macro DMEM_BYTE_MASK_EN enables per-byte write masking via dmem_be.
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_use,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          req_we_r;
  logic [31:0]   req_addr_r;
  logic [31:0]   req_wdata_r;
  logic [3:0]    req_be_r;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          cur_we_s;
  logic [31:0]   cur_addr_s;
  logic [31:0]   cur_wdata_s;
  logic [3:0]    cur_be_s;
  logic [AW-1:0] cur_idx_s;
  logic          cur_err_s;
  logic          enter_resp_s;
  logic          mem_wr_s;
  logic [31:0]   rdata_nxt_s;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  // Request in flight: live inputs while accepting, latched copy afterwards.
  always_comb begin
    if (state_r == S_IDLE) begin
      cur_we_s    = dmem_we;
      cur_addr_s  = dmem_addr;
      cur_wdata_s = dmem_wdata;
      cur_be_s    = dmem_be;
    end else begin
      cur_we_s    = req_we_r;
      cur_addr_s  = req_addr_r;
      cur_wdata_s = req_wdata_r;
      cur_be_s    = req_be_r;
    end
    cur_idx_s = cur_addr_s[AW+1:2];
    cur_err_s = addr_err(cur_addr_s);
  end

  // Response-entry decision and the data presented when entering RESP.
  always_comb begin
    case (state_r)
      S_IDLE:  enter_resp_s = dmem_use && (LATENCY == 1);
      S_WAIT:  enter_resp_s = dmem_use && (cnt_r == 4'd1);
      default: enter_resp_s = 1'b0;
    endcase
    mem_wr_s = enter_resp_s && cur_we_s && !cur_err_s;
    if (cur_err_s) begin
      rdata_nxt_s = 32'h0000_0000;
    end else if (cur_we_s) begin
      rdata_nxt_s = dmem_rdata;
    end else begin
      rdata_nxt_s = mem_r[cur_idx_s];
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      req_we_r    <= 1'b0;
      req_addr_r  <= 32'h0000_0000;
      req_wdata_r <= 32'h0000_0000;
      req_be_r    <= 4'b0000;
      dmem_ready  <= 1'b0;
      dmem_err    <= 1'b0;
      dmem_rdata  <= 32'h0000_0000;
    end else begin
      dmem_ready <= 1'b0;
      dmem_err   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (dmem_use) begin
            req_we_r    <= dmem_we;
            req_addr_r  <= dmem_addr;
            req_wdata_r <= dmem_wdata;
            req_be_r    <= dmem_be;
            if (enter_resp_s) begin
              state_r    <= S_RESP;
              cnt_r      <= 4'd0;
              dmem_ready <= 1'b1;
              dmem_err   <= cur_err_s;
              dmem_rdata <= rdata_nxt_s;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= LAT_LOAD;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT: begin
          // Requester withdrawing mid-wait aborts without side effects.
          if (!dmem_use) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
          end else if (enter_resp_s) begin
            state_r    <= S_RESP;
            cnt_r      <= 4'd0;
            dmem_ready <= 1'b1;
            dmem_err   <= cur_err_s;
            dmem_rdata <= rdata_nxt_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  // Backing array update, byte lanes gated by the write mask.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be_s[i]) begin
          mem_r[cur_idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
        end
      end
    end
  end
`else
  logic unused_be_s;
  assign unused_be_s = ^cur_be_s;

  // Backing array update, always a full word.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[cur_idx_s] <= cur_wdata_s;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level reference model
// plus directed vectors with hand-computed expectations.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_use = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [3:0]  dmem_be = 4'h0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;

  logic        use3 = 1'b0;
  logic [31:0] rdata3;
  logic        ready3;
  logic        err3;

  int n_pass  = 0;
  int n_total = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    bit          err;
    bit          upd;
    logic [31:0] rd;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_hold = 32'h0;

  dmem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .dmem_use(dmem_use), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .dmem_err(dmem_err)
  );

  dmem_responder #(.LATENCY(3), .DEPTH_WORDS(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .dmem_use(use3), .dmem_we(1'b0),
    .dmem_addr(32'h0), .dmem_wdata(32'h0), .dmem_be(4'h0),
    .dmem_rdata(rdata3), .dmem_ready(ready3), .dmem_err(err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old;
`ifdef DMEM_BYTE_MASK_EN
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
`else
    r = wd;
`endif
    return r;
  endfunction

  // Per-cycle comparison of the main DUT against the reference model.
  always @(negedge clk) begin
    bit ex_rdy;
    bit ex_err;
    if (rst) begin
      exp_q.delete();
      exp_hold = 32'h0;
      ex_rdy = 1'b0;
      ex_err = 1'b0;
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ex_rdy = 1'b1;
      ex_err = exp_q[0].err;
      if (exp_q[0].upd) exp_hold = exp_q[0].rd;
      void'(exp_q.pop_front());
    end else begin
      ex_rdy = 1'b0;
      ex_err = 1'b0;
    end
    chk("cmp_ready", {31'h0, dmem_ready}, {31'h0, ex_rdy});
    chk("cmp_err",   {31'h0, dmem_err},   {31'h0, ex_err});
    chk("cmp_rdata", dmem_rdata, exp_hold);
  end

  // mode 0: complete; 1: abort in WAIT; 2: reset in WAIT; 3: reset in RESP (reads only)
  task automatic req(input bit wait_edge, input int mode, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int unsigned acc;
    bit          e;
    int unsigned idx;
    resp_t       r;
    if (wait_edge) begin
      @(posedge clk); #1;
    end
    dmem_use = 1'b1; dmem_we = we; dmem_addr = addr; dmem_wdata = wd; dmem_be = be;
    acc = cyc;
    e   = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
    idx = int'(addr[9:2]);
    case (mode)
      0: begin
        r.cyc = acc + LAT;
        r.err = e;
        r.upd = !we || e;
        r.rd  = e ? 32'h0 : ref_mem[idx];
        exp_q.push_back(r);
        if (we && !e) ref_mem[idx] = merge_word(ref_mem[idx], wd, be);
        repeat (LAT) @(posedge clk);
        #1;
        dmem_use = 1'b0;
      end
      1: begin
        @(posedge clk); #1;
        dmem_use = 1'b0;
      end
      2: begin
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_wait_ready", {31'h0, dmem_ready}, 32'h0);
        chk("rst_wait_err",   {31'h0, dmem_err},   32'h0);
        chk("rst_wait_rdata", dmem_rdata, 32'h0);
        dmem_use = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      3: begin
        repeat (LAT) @(posedge clk);
        #1;
        chk("rst_resp_pre_ready", {31'h0, dmem_ready}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_resp_ready", {31'h0, dmem_ready}, 32'h0);
        chk("rst_resp_err",   {31'h0, dmem_err},   32'h0);
        chk("rst_resp_rdata", dmem_rdata, 32'h0);
        dmem_use = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      default: dmem_use = 1'b0;
    endcase
  endtask

  initial begin
    int unsigned s;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, dmem_ready}, 32'h0);
    chk("reset_err",   {31'h0, dmem_err},   32'h0);
    chk("reset_rdata", dmem_rdata, 32'h0);
    rst = 1'b0;

    req(1'b1, 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr10_ready", {31'h0, dmem_ready}, 32'h1);
    chk("wr10_err",   {31'h0, dmem_err},   32'h0);
    req(1'b1, 0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rd10_rdata", dmem_rdata, 32'hDEADBEEF);

    req(1'b1, 0, 1'b1, 32'h0,   32'h12345678, 4'hF);
    req(1'b1, 0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF);
    req(1'b1, 0, 1'b0, 32'h3FC, 32'h0, 4'h0);
    chk("rd_last_rdata", dmem_rdata, 32'hCAFEF00D);

    req(1'b1, 0, 1'b0, 32'h12, 32'h0, 4'h0);
    chk("mis_ready", {31'h0, dmem_ready}, 32'h1);
    chk("mis_err",   {31'h0, dmem_err},   32'h1);
    chk("mis_rdata", dmem_rdata, 32'h0);
    req(1'b1, 0, 1'b0, 32'h400, 32'h0, 4'h0);
    chk("oob_err", {31'h0, dmem_err}, 32'h1);
    req(1'b1, 0, 1'b1, 32'h12,  32'h55555555, 4'hF);
    req(1'b1, 0, 1'b1, 32'h400, 32'h99999999, 4'hF);
    req(1'b1, 0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("err_nowr_10", dmem_rdata, 32'hDEADBEEF);
    req(1'b1, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("err_nowr_0", dmem_rdata, 32'h12345678);

    req(1'b1, 1, 1'b1, 32'h10, 32'h11111111, 4'hF);
    req(1'b1, 0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("abort_rd", dmem_rdata, 32'hDEADBEEF);

    req(1'b1, 0, 1'b1, 32'h20, 32'h00000000, 4'hF);
    req(1'b1, 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    req(1'b1, 0, 1'b0, 32'h20, 32'h0, 4'h0);
`ifdef DMEM_BYTE_MASK_EN
    chk("mask_rd", dmem_rdata, 32'h00BB00DD);
`else
    chk("mask_rd", dmem_rdata, 32'hAABBCCDD);
`endif
    req(1'b1, 0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    req(1'b1, 0, 1'b0, 32'h20, 32'h0, 4'h0);
`ifdef DMEM_BYTE_MASK_EN
    chk("be0_rd", dmem_rdata, 32'h00BB00DD);
`else
    chk("be0_rd", dmem_rdata, 32'hFFFFFFFF);
`endif

    req(1'b1, 0, 1'b1, 32'h24, 32'h0BADC0DE, 4'hF);
    req(1'b1, 0, 1'b0, 32'h24, 32'h0, 4'h0);
    chk("raw_rd", dmem_rdata, 32'h0BADC0DE);

    req(1'b1, 3, 1'b0, 32'h10, 32'h0, 4'h0);
    req(1'b1, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    req(1'b1, 2, 1'b1, 32'h10, 32'h77777777, 4'hF);
    req(1'b0, 0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("rst_nowr_rd", dmem_rdata, 32'hDEADBEEF);

    // Continuous requests at LATENCY=3: pulses at 3, 7, 11 only.
    @(posedge clk); #1;
    use3 = 1'b1;
    s = cyc;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk($sformatf("thru_k%0d", k), {31'h0, ready3},
          {31'h0, (k == 3 || k == 7 || k == 11) ? 1'b1 : 1'b0});
      chk($sformatf("thru_err_k%0d", k), {31'h0, err3}, 32'h0);
    end
    chk("thru_start", cyc - s, 32'd12);
    use3 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
